ccs_gen: RTL and testbench

CCS_GEN -- requirements
Module: ccs_gen

---
 rtl/ccs_gen.sv | 136 +++++++++++++
 tb/tb_ccs_gen.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccs_gen.sv
// Round-robin, credit-gated arbiter driving one crossbar output select for FLITS-cycle packets.
// Latency: grant appears on xbar_cfg_vector/arb_ack the cycle after a start edge; packets chain back-to-back.
// Backpressure: no start while crd_count==0; a returned credit re-enables arbitration on the next edge.
module ccs_gen #(
  parameter int PORTS   = 5,
  parameter int CREDITS = 4,
  parameter int FLITS   = 4
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               credit_in,
  input  logic [PORTS-1:0]                   port_rqs,
  output logic [PORTS-1:0]                   arb_ack,
  output logic [PORTS-1:0]                   xbar_cfg_vector,
  output logic [$clog2(CREDITS+1)-1:0]       crd_count,
  output logic                               busy,
  output logic                               crd_err
);

  localparam int CW   = $clog2(CREDITS + 1);
  localparam int CNTW = $clog2(FLITS);

  typedef enum logic [1:0] {IDLE, NEW, PULL} state_t;

  state_t            state, state_nxt;
  logic [CNTW-1:0]   cnt, cnt_nxt;
  logic [PORTS-1:0]  ptr, ptr_nxt;
  logic [PORTS-1:0]  xbar, xbar_nxt;
  logic [PORTS-1:0]  grant;
  logic [CW-1:0]     crd, crd_nxt;
  logic              err, err_nxt;
  logic              start;
  logic              found;
  int                p_idx;
  int                idx;

  // Round-robin pick: scan upward from the pointer position, wrapping, first requester wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    p_idx = 0;
    idx   = 0;
    for (int i = 0; i < PORTS; i++) begin
      if (ptr[i]) p_idx = i;
    end
    for (int k = 0; k < PORTS; k++) begin
      idx = p_idx + k;
      if (idx >= PORTS) idx = idx - PORTS;
      if (!found && port_rqs[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  // Arbitration is allowed only between packets and only with a credit in hand.
  assign start = ((state == IDLE) || ((state == PULL) && (cnt == '0))) &&
                 (|port_rqs) && (crd != '0);

  // Next-state, packet timing and acknowledge generation.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    xbar_nxt  = xbar;
    ptr_nxt   = ptr;
    arb_ack   = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = NEW;
          xbar_nxt  = grant;
          cnt_nxt   = CNTW'(FLITS - 1);
        end
      end
      NEW: begin
        arb_ack   = xbar;
        ptr_nxt   = {xbar[PORTS-2:0], xbar[PORTS-1]};
        cnt_nxt   = cnt - CNTW'(1);
        state_nxt = PULL;
      end
      PULL: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNTW'(1);
        end else if (start) begin
          state_nxt = NEW;
          xbar_nxt  = grant;
          cnt_nxt   = CNTW'(FLITS - 1);
        end else begin
          state_nxt = IDLE;
          xbar_nxt  = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        xbar_nxt  = '0;
      end
    endcase
  end

  // Credit bookkeeping: a start and a returned credit in the same cycle cancel out.
  always_comb begin
    crd_nxt = crd;
    err_nxt = err;
    if (start && !credit_in) begin
      crd_nxt = crd - CW'(1);
    end else if (!start && credit_in) begin
      if (crd == CW'(CREDITS)) err_nxt = 1'b1;
      else                     crd_nxt = crd + CW'(1);
    end
  end

  // State and datapath registers; reset aborts any packet in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      ptr   <= PORTS'(1);
      xbar  <= '0;
      crd   <= CW'(CREDITS);
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ptr   <= ptr_nxt;
      xbar  <= xbar_nxt;
      crd   <= crd_nxt;
      err   <= err_nxt;
    end
  end

  assign xbar_cfg_vector = xbar;
  assign crd_count       = crd;
  assign busy            = (state != IDLE);
  assign crd_err         = err;

endmodule

// File: tb/tb_ccs_gen.sv
// Bench for ccs_gen: directed scenarios plus randomized traffic against a packet-level model.
// Outputs are compared every falling edge and at chosen points between edges.
// Inputs change 1 time unit after each rising edge.
module tb_ccs_gen;

  localparam int P = 5;
  localparam int C = 4;
  localparam int F = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         credit_in = 1'b0;
  logic [P-1:0] port_rqs = '0;
  logic [P-1:0] arb_ack;
  logic [P-1:0] xbar_cfg_vector;
  logic [2:0]   crd_count;
  logic         busy;
  logic         crd_err;

  int n_chk  = 0;
  int n_fail = 0;

  ccs_gen #(.PORTS(P), .CREDITS(C), .FLITS(F)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .credit_in       (credit_in),
    .port_rqs        (port_rqs),
    .arb_ack         (arb_ack),
    .xbar_cfg_vector (xbar_cfg_vector),
    .crd_count       (crd_count),
    .busy            (busy),
    .crd_err         (crd_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Packet-level model: which port owns the output, how far into its packet, credits, error.
  int m_cur;
  int m_age;
  int m_ptr;
  int m_crd;
  bit m_err;

  function automatic void m_reset();
    m_cur = -1;
    m_age = 0;
    m_ptr = 0;
    m_crd = C;
    m_err = 1'b0;
  endfunction

  function automatic logic [P-1:0] m_xbar();
    logic [P-1:0] v = '0;
    if (m_cur >= 0) v[m_cur] = 1'b1;
    return v;
  endfunction

  function automatic logic [P-1:0] m_ack();
    if (m_cur >= 0 && m_age == 0) return m_xbar();
    return '0;
  endfunction

  task automatic m_step();
    bit can;
    int w;
    can = (m_cur < 0 || m_age == F - 1) && (port_rqs != '0) && (m_crd > 0);
    w = -1;
    if (can) begin
      for (int k = 0; k < P; k++) begin
        int j;
        j = (m_ptr + k) % P;
        if (w < 0 && port_rqs[j]) w = j;
      end
    end
    if (credit_in && !can) begin
      if (m_crd == C) m_err = 1'b1;
      else            m_crd++;
    end
    if (can) begin
      if (!credit_in) m_crd--;
      m_cur = w;
      m_age = 0;
      m_ptr = (w + 1) % P;
    end else if (m_cur >= 0) begin
      if (m_age == F - 1) m_cur = -1;
      else                m_age++;
    end
  endtask

  always @(negedge reset_n) m_reset();

  always @(posedge clk) if (reset_n) m_step();

  always @(negedge clk) begin
    check("xbar", xbar_cfg_vector, m_xbar());
    check("ack", arb_ack, m_ack());
    check("crd", crd_count, m_crd);
    check("busy", busy, (m_cur >= 0));
    check("err", crd_err, m_err);
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int grants;
    int guard;
    m_reset();

    // Reset values while reset is held
    repeat (2) @(posedge clk);
    #3;
    check("rst_xbar", xbar_cfg_vector, 5'b00000);
    check("rst_ack", arb_ack, 5'b00000);
    check("rst_crd", crd_count, 3'd4);
    check("rst_busy", busy, 1'b0);
    check("rst_err", crd_err, 1'b0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Single-cycle request on port 2
    port_rqs = 5'b00100;
    step();
    port_rqs = '0;
    check("p1_xbar", xbar_cfg_vector, 5'b00100);
    check("p1_ack", arb_ack, 5'b00100);
    check("p1_crd", crd_count, 3'd3);
    check("p1_busy", busy, 1'b1);
    for (int i = 1; i < F; i++) begin
      step();
      check("p1_hold", xbar_cfg_vector, 5'b00100);
      check("p1_ack0", arb_ack, 5'b00000);
      check("p1_busyh", busy, 1'b1);
    end
    step();
    check("p1_end_xbar", xbar_cfg_vector, 5'b00000);
    check("p1_end_busy", busy, 1'b0);

    // One more packet to bring credits to 2
    port_rqs = 5'b00001;
    step();
    port_rqs = '0;
    step(4);
    check("pre_coinc_crd", crd_count, 3'd2);

    // Credit return coinciding with a start
    port_rqs  = 5'b00010;
    credit_in = 1'b1;
    step();
    port_rqs  = '0;
    credit_in = 1'b0;
    check("coinc_crd", crd_count, 3'd2);
    check("coinc_xbar", xbar_cfg_vector, 5'b00010);
    step(4);

    // Two requesters held, credit returned each packet: alternating back-to-back grants
    port_rqs = 5'b10001;
    step();
    for (int n = 0; n < 4 * F; n++) begin
      check("b2b_busy", busy, 1'b1);
      if (n % F == 0)
        check("b2b_grant", arb_ack, ((n / F) % 2 == 0) ? 5'b10000 : 5'b00001);
      credit_in = (n % F == 0);
      step();
    end
    credit_in = 1'b0;
    port_rqs  = '0;
    check("b2b_last", arb_ack, 5'b10000);
    step(F);
    check("b2b_idle", busy, 1'b0);

    // Refill credits, then drain them with a held request
    credit_in = 1'b1;
    step(3);
    credit_in = 1'b0;
    check("refill_crd", crd_count, 3'd4);
    port_rqs = 5'b00010;
    grants = 0;
    guard  = 0;
    while (guard < 60) begin
      step();
      guard++;
      if (arb_ack != '0) grants++;
      if (!busy && crd_count == 0) break;
    end
    if (guard >= 60) check("drain_timeout", 0, 1);
    check("drain_grants", grants, 4);
    check("drain_crd", crd_count, 3'd0);
    check("drain_xbar", xbar_cfg_vector, 5'b00000);
    check("drain_busy", busy, 1'b0);
    step(2);
    check("starved_busy", busy, 1'b0);
    credit_in = 1'b1;
    step();
    credit_in = 1'b0;
    check("ret_crd", crd_count, 3'd1);
    check("ret_busy", busy, 1'b0);
    step();
    check("fifth_xbar", xbar_cfg_vector, 5'b00010);
    check("fifth_ack", arb_ack, 5'b00010);
    check("fifth_crd", crd_count, 3'd0);
    port_rqs = '0;
    step(F);
    credit_in = 1'b1;
    step(4);
    credit_in = 1'b0;
    check("full_crd", crd_count, 3'd4);
    check("full_err", crd_err, 1'b0);

    // Credit overflow while full and idle
    credit_in = 1'b1;
    step();
    credit_in = 1'b0;
    check("ovf_crd", crd_count, 3'd4);
    check("ovf_err", crd_err, 1'b1);
    step(3);
    check("ovf_sticky", crd_err, 1'b1);

    // Reset in the third PULL cycle
    port_rqs = 5'b11111;
    step();
    step(3);
    check("mid_busy", busy, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_xbar", xbar_cfg_vector, 5'b00000);
    check("arst_ack", arb_ack, 5'b00000);
    check("arst_crd", crd_count, 3'd4);
    check("arst_err", crd_err, 1'b0);
    check("arst_busy", busy, 1'b0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    step();
    check("post_rst_xbar", xbar_cfg_vector, 5'b00001);
    check("post_rst_ack", arb_ack, 5'b00001);
    port_rqs = '0;
    step(F);

    // Randomized traffic with occasional asynchronous resets
    for (int c = 0; c < 2000; c++) begin
      if (c % 400 < 200) port_rqs = P'($urandom) & P'($urandom);
      else               port_rqs = P'($urandom);
      credit_in = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 249) == 0) begin
        #2 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
      end else begin
        step();
      end
    end
    port_rqs  = '0;
    credit_in = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
